// File: rtl/mem_wb_stage.sv
// mem_wb_stage: RV32I memory-access stage with data memory and MEM/WB register.
// Loads/stores of byte, halfword and word with extension and alignment checks.
module mem_wb_stage #(
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  mrn,
  input  logic [31:0] mb,
  input  logic [31:0] malu,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic        mwreg,
  input  logic [2:0]  mfunct3,
  input  logic        mstall,
  output logic [4:0]  wrn,
  output logic [31:0] walu,
  output logic [31:0] wmo,
  output logic        wm2reg,
  output logic        wwreg,
  output logic        wfault,
  output logic [31:0] wdi
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  logic [31:0]   dmem [DMEM_WORDS];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rdata;
  logic          access;
  logic          misaligned;
  logic          f3_illegal;
  logic          fault;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ldata;
  logic          unused_addr;

  // Address split: upper bits beyond the memory size wrap and are ignored.
  assign idx         = malu[AW+1:2];
  assign lane        = malu[1:0];
  assign rdata       = dmem[idx];
  assign unused_addr = ^malu[31:AW+2];

  // Fault detection and store enable (no write while stalled, faulting or in reset).
  always_comb begin
    access     = mwmem | mm2reg;
    misaligned = 1'b0;
    case (mfunct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    f3_illegal = (mm2reg & ((mfunct3 == 3'b011) | (mfunct3[2:1] == 2'b11)))
               | (mwmem  & (mfunct3[2] | (mfunct3[1:0] == 2'b11)));
    fault      = access & (misaligned | f3_illegal);
    we         = mwmem & ~mstall & ~fault & rst_n;
  end

  // Store lane steering: replicate data across lanes, enable the addressed bytes.
  always_comb begin
    be    = 4'b0000;
    wdata = mb;
    case (mfunct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{mb[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mb[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load extraction with sign/zero extension; zero for non-loads and faults.
  always_comb begin
    ld_byte = rdata[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? rdata[31:16] : rdata[15:0];
    ldata   = 32'h0;
    if (mm2reg && !mwmem && !fault) begin
      case (mfunct3)
        3'b000:  ldata = {{24{ld_byte[7]}}, ld_byte};
        3'b001:  ldata = {{16{ld_half[15]}}, ld_half};
        3'b010:  ldata = rdata;
        3'b100:  ldata = {24'h0, ld_byte};
        3'b101:  ldata = {16'h0, ld_half};
        default: ldata = 32'h0;
      endcase
    end
  end

  // Data memory: synchronous per-byte write, contents never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) dmem[idx][7:0]   <= wdata[7:0];
      if (be[1]) dmem[idx][15:8]  <= wdata[15:8];
      if (be[2]) dmem[idx][23:16] <= wdata[23:16];
      if (be[3]) dmem[idx][31:24] <= wdata[31:24];
    end
  end

  // MEM/WB pipeline register, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrn    <= 5'd0;
      walu   <= 32'h0;
      wmo    <= 32'h0;
      wm2reg <= 1'b0;
      wwreg  <= 1'b0;
      wfault <= 1'b0;
    end else if (!mstall) begin
      wrn    <= mrn;
      walu   <= malu;
      wmo    <= ldata;
      wm2reg <= mm2reg;
      wwreg  <= mwreg & ~fault;
      wfault <= fault;
    end
  end

  // Writeback data mux.
  assign wdi = wm2reg ? wmo : walu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage using a byte-array memory model.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic [4:0]  mrn;
  logic [31:0] mb;
  logic [31:0] malu;
  logic        mwmem;
  logic        mm2reg;
  logic        mwreg;
  logic [2:0]  mfunct3;
  logic        mstall;
  logic [4:0]  wrn;
  logic [31:0] walu;
  logic [31:0] wmo;
  logic        wm2reg;
  logic        wwreg;
  logic        wfault;
  logic [31:0] wdi;

  typedef struct packed {
    logic [4:0]  rn;
    logic [31:0] alu;
    logic [31:0] mo;
    logic        m2;
    logic        wr;
    logic        flt;
  } exp_t;

  exp_t       sbq[$];
  exp_t       last;
  logic [7:0] model_mem [1024];
  int         checks;
  int         errors;

  mem_wb_stage #(.DMEM_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n), .mrn(mrn), .mb(mb), .malu(malu),
    .mwmem(mwmem), .mm2reg(mm2reg), .mwreg(mwreg), .mfunct3(mfunct3),
    .mstall(mstall), .wrn(wrn), .walu(walu), .wmo(wmo), .wm2reg(wm2reg),
    .wwreg(wwreg), .wfault(wfault), .wdi(wdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".wrn"},    32'(wrn),    32'(e.rn));
    check({tag, ".walu"},   walu,        e.alu);
    check({tag, ".wmo"},    wmo,         e.mo);
    check({tag, ".wm2reg"}, 32'(wm2reg), 32'(e.m2));
    check({tag, ".wwreg"},  32'(wwreg),  32'(e.wr));
    check({tag, ".wfault"}, 32'(wfault), 32'(e.flt));
    check({tag, ".wdi"},    wdi,         e.m2 ? e.mo : e.alu);
  endtask

  // Reference behaviour on a flat byte array; applies committed stores.
  task automatic model_op(input logic [4:0] rn, input logic [31:0] b, input logic [31:0] alu,
                          input logic wm, input logic m2, input logic wr, input logic [2:0] f3,
                          output exp_t e);
    logic [9:0]  a;
    logic        bad;
    logic        flt;
    logic [31:0] w;
    int          n;
    a   = alu[9:0];
    n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad = 1'b0;
    if (f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
    if (f3[1:0] == 2'b11) bad = 1'b1;
    if (m2 && f3 == 3'b110) bad = 1'b1;
    if (wm && f3[2]) bad = 1'b1;
    flt = (wm | m2) & bad;
    w   = 32'h0;
    if (wm && !flt) begin
      for (int i = 0; i < n; i++) model_mem[10'(a + 10'(i))] = b[8*i +: 8];
    end else if (m2 && !wm && !flt) begin
      for (int i = 0; i < n; i++) w[8*i +: 8] = model_mem[10'(a + 10'(i))];
      if (!f3[2] && n == 1) w = {{24{w[7]}}, w[7:0]};
      if (!f3[2] && n == 2) w = {{16{w[15]}}, w[15:0]};
    end
    e.rn  = rn;
    e.alu = alu;
    e.mo  = w;
    e.m2  = m2;
    e.wr  = wr & ~flt;
    e.flt = flt;
  endtask

  // Drive one MEM-stage cycle; unstalled ops go through the scoreboard, stalled ones expect held outputs.
  task automatic op(input string tag, input logic [4:0] rn, input logic [31:0] b, input logic [31:0] alu,
                    input logic wm, input logic m2, input logic wr, input logic [2:0] f3, input logic st);
    exp_t e;
    @(negedge clk);
    mrn = rn; mb = b; malu = alu; mwmem = wm; mm2reg = m2; mwreg = wr; mfunct3 = f3; mstall = st;
    if (!st) begin
      model_op(rn, b, alu, wm, m2, wr, f3, e);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (st) begin
      check_outs({tag, ".hold"}, last);
    end else if (sbq.size() == 0) begin
      check({tag, ".sbq_empty"}, 32'd1, 32'd0);
    end else begin
      last = sbq.pop_front();
      check_outs(tag, last);
    end
  endtask

  task automatic sw(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    op(tag, 5'd0, data, addr, 1'b1, 1'b0, 1'b0, f3, 1'b0);
  endtask

  task automatic ld(input string tag, input logic [4:0] rn, input logic [31:0] addr, input logic [2:0] f3);
    op(tag, rn, 32'h0, addr, 1'b0, 1'b1, 1'b1, f3, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    exp_t z;
    z = '0;
    check_outs(tag, z);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; last = '0;
    rst_n = 1'b0; mrn = '0; mb = '0; malu = '0; mwmem = 1'b0; mm2reg = 1'b0;
    mwreg = 1'b0; mfunct3 = '0; mstall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    sw("sw10", 32'h10, 32'hDEADBEEF, 3'b010);
    ld("lw10", 5'd5, 32'h10, 3'b010);
    check("lw10.lit", wdi, 32'hDEADBEEF);
    sw("sb13", 32'h13, 32'h0000005A, 3'b000);
    ld("lb13", 5'd6, 32'h13, 3'b000);
    check("lb13.lit", wmo, 32'h0000005A);
    ld("lw10b", 5'd7, 32'h10, 3'b010);
    check("lw10b.lit", wmo, 32'h5AADBEEF);
    ld("lb11", 5'd8, 32'h11, 3'b000);
    check("lb11.lit", wmo, 32'hFFFFFFBE);
    ld("lbu11", 5'd9, 32'h11, 3'b100);
    check("lbu11.lit", wmo, 32'h000000BE);

    sw("sw20", 32'h20, 32'h11223344, 3'b010);
    sw("sh22", 32'h22, 32'h00008001, 3'b001);
    ld("lh22", 5'd10, 32'h22, 3'b001);
    check("lh22.lit", wmo, 32'hFFFF8001);
    ld("lhu22", 5'd11, 32'h22, 3'b101);
    check("lhu22.lit", wmo, 32'h00008001);
    ld("lw20", 5'd12, 32'h20, 3'b010);
    check("lw20.lit", wmo, 32'h80013344);

    sw("sw100", 32'h100, 32'hCAFEF00D, 3'b010);
    sw("sh101", 32'h101, 32'h00001234, 3'b001);
    check("sh101.fault", 32'(wfault), 32'd1);
    ld("lw100", 5'd13, 32'h100, 3'b010);
    check("lw100.lit", wmo, 32'hCAFEF00D);
    ld("lw102", 5'd14, 32'h102, 3'b010);
    check("lw102.fault", 32'(wfault), 32'd1);
    ld("lh103", 5'd15, 32'h103, 3'b001);
    ld("ld011", 5'd16, 32'h100, 3'b011);
    check("ld011.fault", 32'(wfault), 32'd1);
    ld("ld110", 5'd17, 32'h100, 3'b110);
    sw("st100", 32'h100, 32'hFFFFFFFF, 3'b100);
    ld("lw100b", 5'd18, 32'h100, 3'b010);
    op("alu", 5'd19, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 3'b111, 1'b0);

    sw("sw400", 32'h400, 32'h12345678, 3'b010);
    ld("lw000", 5'd20, 32'h000, 3'b010);
    check("lw000.lit", wmo, 32'h12345678);

    op("both", 5'd21, 32'h00000077, 32'h50, 1'b1, 1'b1, 1'b1, 3'b010, 1'b0);
    ld("lw50", 5'd22, 32'h50, 3'b010);

    // Stalled store replaced before release must not write.
    sw("sw44", 32'h44, 32'h55667788, 3'b010);
    repeat (2) op("st44", 5'd0, 32'h99999999, 32'h44, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1);
    op("nop44", 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    ld("lw44", 5'd23, 32'h44, 3'b010);
    check("lw44.lit", wmo, 32'h55667788);

    // Store held three cycles then released writes once.
    sw("sw40", 32'h40, 32'h11112222, 3'b010);
    repeat (3) op("st40", 5'd0, 32'hAAAA5555, 32'h40, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1);
    sw("sw40r", 32'h40, 32'hAAAA5555, 3'b010);
    ld("lw40", 5'd24, 32'h40, 3'b010);
    check("lw40.lit", wmo, 32'hAAAA5555);

    // Asynchronous reset mid-cycle with a store pending at the next edge.
    @(negedge clk);
    mrn = 5'd3; mb = 32'hBBBBBBBB; malu = 32'h40; mwmem = 1'b1; mm2reg = 1'b0;
    mwreg = 1'b1; mfunct3 = 3'b010; mstall = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    @(posedge clk);
    #1 check_zero("rst_edge");
    @(negedge clk);
    mwmem = 1'b0; mwreg = 1'b0;
    rst_n = 1'b1;
    sbq.delete();
    ld("lw40r", 5'd25, 32'h40, 3'b010);
    check("lw40r.lit", wmo, 32'hAAAA5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
